// File: rtl/lcd_line_fetch.sv
// Fetches each scanline from frame memory into a ping-pong line buffer and emits panel RGB with realigned syncs.
// Latency: HSYNC/VSYNC/DEN/RGB are the timing inputs delayed by exactly 2 PIXEL_CLK cycles.
// Backpressure: MEM_REQ/MEM_ADDR hold until MEM_ACK; LCD_LINE_FETCH_UNDERRUN_EN enables magenta fill and the sticky UNDERRUN flag.
module lcd_line_fetch #(
    parameter int H_DISPLAY = 480,
    parameter int V_DISPLAY = 272,
    parameter int ADDR_W    = 17
) (
    input  logic              PIXEL_CLK,
    input  logic              RESET,
    input  logic              HSYNC_IN,
    input  logic              VSYNC_IN,
    input  logic              DEN_IN,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DATA,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DEN,
    output logic [15:0]       RGB,
    output logic              UNDERRUN
);

    localparam int COL_W  = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
    localparam int LINE_W = $clog2(V_DISPLAY + 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_DISPLAY - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_DISPLAY - 1);

    typedef enum logic {S_IDLE, S_REQ} fetch_state_t;

    fetch_state_t      state;
    logic              hs_d1, vs_d1, den_d1;
    logic              vs_fall, den_rise, den_fall;
    logic [COL_W-1:0]  col_cnt, rd_col, word;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] nxt_base, pend_base;
    logic              pend, pend_buf, fill, abort;
    logic              take, wr_en, last_word, queue_next;
    logic [15:0]       line_buf0 [H_DISPLAY];
    logic [15:0]       line_buf1 [H_DISPLAY];
    logic [15:0]       rd_data, pix;

    // Edges are taken against the first pipeline stage, which doubles as the previous-cycle input.
    assign vs_fall    = vs_d1 & ~VSYNC_IN;
    assign den_rise   = DEN_IN & ~den_d1;
    assign den_fall   = ~DEN_IN & den_d1;
    assign rd_col     = den_rise ? '0 : col_cnt;
    assign queue_next = den_rise && (line_cnt < LAST_LINE);
    // A frame start in the same cycle as a pending take wins: the stale fetch is never started.
    assign take       = (state == S_IDLE) && pend && !vs_fall;
    assign last_word  = (word == LAST_COL);
    assign wr_en      = (state == S_REQ) && MEM_ACK && !abort && !vs_fall;

    // Two-stage delay of the timing inputs; stage 2 drives the panel.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            hs_d1 <= 1'b1; vs_d1 <= 1'b1; den_d1 <= 1'b0;
            HSYNC <= 1'b1; VSYNC <= 1'b1; DEN <= 1'b0;
        end else begin
            hs_d1 <= HSYNC_IN; vs_d1 <= VSYNC_IN; den_d1 <= DEN_IN;
            HSYNC <= hs_d1;    VSYNC <= vs_d1;    DEN <= den_d1;
        end
    end

    // Column/line counters, running line base and the single-entry fetch queue.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            col_cnt   <= '0;
            line_cnt  <= '0;
            nxt_base  <= '0;
            pend      <= 1'b0;
            pend_base <= '0;
            pend_buf  <= 1'b0;
        end else begin
            if (take)
                pend <= 1'b0;
            if (vs_fall) begin
                col_cnt   <= '0;
                line_cnt  <= '0;
                nxt_base  <= ADDR_W'(H_DISPLAY);
                pend      <= 1'b1;
                pend_base <= '0;
                pend_buf  <= 1'b0;
            end else begin
                if (DEN_IN)
                    col_cnt <= (rd_col == LAST_COL) ? rd_col : rd_col + COL_W'(1);
                if (den_fall) begin
                    if (line_cnt != LINE_W'(V_DISPLAY))
                        line_cnt <= line_cnt + LINE_W'(1);
                    nxt_base <= nxt_base + ADDR_W'(H_DISPLAY);
                end
                // A newer request overwrites one still waiting for the FSM.
                if (queue_next) begin
                    pend      <= 1'b1;
                    pend_base <= nxt_base;
                    pend_buf  <= ~line_cnt[0];
                end
            end
        end
    end

    // Fetch FSM: one word per handshake; an abort finishes the open handshake and drops its data.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= '0;
            word     <= '0;
            fill     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state    <= S_REQ;
                        MEM_REQ  <= 1'b1;
                        MEM_ADDR <= pend_base;
                        fill     <= pend_buf;
                        word     <= '0;
                        abort    <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (MEM_ACK) begin
                        if (abort || vs_fall || last_word) begin
                            state   <= S_IDLE;
                            MEM_REQ <= 1'b0;
                            abort   <= 1'b0;
                        end else begin
                            word     <= word + COL_W'(1);
                            MEM_ADDR <= MEM_ADDR + ADDR_W'(1);
                        end
                    end else if (vs_fall) begin
                        abort <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line buffer write port.
    always_ff @(posedge PIXEL_CLK) begin
        if (wr_en) begin
            if (fill)
                line_buf1[word] <= MEM_DATA;
            else
                line_buf0[word] <= MEM_DATA;
        end
    end

    // Synchronous display read; line y always comes from buffer y[0].
    always_ff @(posedge PIXEL_CLK) begin
        rd_data <= line_cnt[0] ? line_buf1[rd_col] : line_buf0[rd_col];
    end

`ifdef LCD_LINE_FETCH_UNDERRUN_EN
    logic [1:0] rdy;
    logic       udr_line;

    // Buffer-ready flags: set on the final word, cleared at frame start or when a buffer is re-queued.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            rdy <= '0;
        end else begin
            if (wr_en && last_word)
                rdy[fill] <= 1'b1;
            if (vs_fall)
                rdy <= '0;
            else if (queue_next)
                rdy[~line_cnt[0]] <= 1'b0;
        end
    end

    // Underrun decided once per line at DEN_IN rising; UNDERRUN latches with the first pixel out.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            udr_line <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            if (vs_fall)
                udr_line <= 1'b0;
            else if (den_rise)
                udr_line <= ~rdy[line_cnt[0]];
            if (den_d1 && udr_line)
                UNDERRUN <= 1'b1;
        end
    end

    assign pix = udr_line ? 16'hF81F : rd_data;
`else
    assign UNDERRUN = 1'b0;
    assign pix      = rd_data;
`endif

    // Output pixel register, blanked whenever DEN is low.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET)
            RGB <= '0;
        else
            RGB <= den_d1 ? pix : 16'h0000;
    end

endmodule

// File: tb/tb_lcd_line_fetch.sv
// Scoreboard bench for lcd_line_fetch with H_DISPLAY=8, V_DISPLAY=4 and a memory whose word equals its address.
// Stimulus changes 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Memory model acks after a programmable number of wait cycles.
module tb_lcd_line_fetch;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 8;
`ifdef LCD_LINE_FETCH_UNDERRUN_EN
    localparam int UDR_ON  = 1;
    localparam int UDR_EXP = 16'hF81F;
`else
    localparam int UDR_ON  = 0;
    localparam int UDR_EXP = -1;   // stale/partial data: only "not magenta" is required
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hs_in = 1'b1, vs_in = 1'b1, den_in = 1'b0;
    logic          mem_req, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data = 16'h0000;
    logic          hsync, vsync, den, underrun;
    logic [15:0]   rgb;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int mem_wait = 0;
    int wcnt = 0;
    bit mon_en = 1'b0;
    bit hs_h1 = 1'b1, hs_h2 = 1'b1, vs_h1 = 1'b1, vs_h2 = 1'b1, den_h1 = 1'b0, den_h2 = 1'b0;
    bit prev_req = 1'b0, prev_ack = 1'b0;
    int prev_addr = 0;

    lcd_line_fetch #(.H_DISPLAY(H), .V_DISPLAY(V), .ADDR_W(AW)) dut (
        .PIXEL_CLK (clk),
        .RESET     (rst),
        .HSYNC_IN  (hs_in),
        .VSYNC_IN  (vs_in),
        .DEN_IN    (den_in),
        .MEM_REQ   (mem_req),
        .MEM_ADDR  (mem_addr),
        .MEM_ACK   (mem_ack),
        .MEM_DATA  (mem_data),
        .HSYNC     (hsync),
        .VSYNC     (vsync),
        .DEN       (den),
        .RGB       (rgb),
        .UNDERRUN  (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame memory: ack after mem_wait idle cycles, data = address.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                if (wcnt >= mem_wait) begin
                    mem_ack  = 1'b1;
                    mem_data = 16'(mem_addr);
                    wcnt     = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Output monitor: sync alignment, scoreboard pops, blanking and address stability.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("hsync_align", hsync, hs_h2);
                chk("vsync_align", vsync, vs_h2);
                chk("den_align", den, den_h2);
                if (den) begin
                    if (exp_q.size() == 0) begin
                        chk("rgb_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e < 0) chk("no_magenta", int'(rgb == 16'hF81F), 0);
                        else       chk("rgb", rgb, e);
                    end
                end else begin
                    chk("rgb_blank", rgb, 0);
                end
                if (prev_req && !prev_ack && mem_req)
                    chk("addr_hold", mem_addr, prev_addr);
            end
            hs_h2 = hs_h1; hs_h1 = hs_in;
            vs_h2 = vs_h1; vs_h1 = vs_in;
            den_h2 = den_h1; den_h1 = den_in;
            prev_req = mem_req; prev_ack = mem_ack; prev_addr = int'(mem_addr);
        end
    end

    task automatic start_frame(input int vblank);
        vs_in = 1'b0;
        tick(); tick();
        vs_in = 1'b1;
        repeat (vblank) tick();
    endtask

    // One line: 2-cycle HSYNC, blank cycles, then H active pixels.
    task automatic drive_line(input int y, input int blank, input bit udr);
        hs_in = 1'b0;
        tick(); tick();
        hs_in = 1'b1;
        repeat (blank) tick();
        for (int x = 0; x < H; x++) begin
            den_in = 1'b1;
            exp_q.push_back(udr ? UDR_EXP : y * H + x);
            tick();
        end
        den_in = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        repeat (4) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int a;
        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_den", den, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_underrun", underrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();
        mon_en = 1'b1;

        // Zero-wait memory, full frame
        mem_wait = 0;
        start_frame(20);
        for (int y = 0; y < V; y++) drive_line(y, 6, 1'b0);
        end_frame("zw_sb_empty");
        chk("zw_underrun", underrun, 0);

        // Three wait cycles per word
        mem_wait = 3;
        start_frame(40);
        for (int y = 0; y < V; y++) drive_line(y, 30, 1'b0);
        end_frame("hs_sb_empty");
        chk("hs_underrun", underrun, 0);

        // VSYNC falls while line 2 is being fetched
        start_frame(40);
        drive_line(0, 30, 1'b0);
        drive_line(1, 30, 1'b0);
        repeat (3) tick();
        chk("ab_in_req", mem_req, 1);
        vs_in = 1'b0;
        got = 1'b0;
        a = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                got = 1'b1;
                a = int'(mem_addr);
            end
        end
        chk("ab_outstanding_ack", int'(got && a >= 2 * H && a < 3 * H), 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!mem_req) got = 1'b1;
        end
        chk("ab_req_drop", got, 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_req) got = 1'b1;
        end
        chk("ab_restart_seen", got, 1);
        chk("ab_restart_addr", mem_addr, 0);
        @(posedge clk); #1;
        vs_in = 1'b1;
        repeat (40) tick();
        for (int y = 0; y < V; y++) drive_line(y, 30, 1'b0);
        end_frame("ab_sb_empty");

        // Memory too slow for line 1 only; later lines have time to refill
        start_frame(40);
        drive_line(0, 30, 1'b0);
        drive_line(1, 2, 1'b1);
        repeat (3) tick();
        chk("slow_underrun_set", underrun, UDR_ON);
        drive_line(2, 60, 1'b0);
        drive_line(3, 60, 1'b0);
        end_frame("slow_sb_empty");
        chk("slow_underrun_sticky", underrun, UDR_ON);

        // Reset while a request is outstanding
        vs_in = 1'b0;
        tick();
        vs_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_req) got = 1'b1;
        end
        chk("rr_req_seen", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b0;
        tick();
        @(negedge clk);
        chk("rr_mem_req", mem_req, 0);
        chk("rr_hsync", hsync, 1);
        chk("rr_vsync", vsync, 1);
        chk("rr_den", den, 0);
        chk("rr_rgb", rgb, 0);
        chk("rr_underrun", underrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) tick();
        chk("rr_mem_req_idle", mem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_line_fetch.md
# lcd_line_fetch

Pixel-data stage directly downstream of the LCD timing generator. It consumes the generator's HSYNC/VSYNC/DEN and fetches each scanline from frame memory, one RGB565 word per handshake, into a ping-pong line buffer. It emits panel-ready RGB with HSYNC/VSYNC/DEN realigned to the pixel data. Frame memory is linear and row-major: word address = line × H_DISPLAY + column.

## Interface
- `H_DISPLAY`, 480: active pixels per line; also the depth of each line buffer.
- `V_DISPLAY`, 272: active lines per frame.
- `ADDR_W`, 17: width of MEM_ADDR; must hold H_DISPLAY×V_DISPLAY−1.
- `PIXEL_CLK` in 1: sole clock; everything is sampled on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `HSYNC_IN` in 1: horizontal sync from the timing generator, active low.
- `VSYNC_IN` in 1: vertical sync from the timing generator, active low.
- `DEN_IN` in 1: data enable from the timing generator, high during active pixels.
- `MEM_REQ` out 1: read request to frame memory.
- `MEM_ADDR` out ADDR_W: word address of the current request.
- `MEM_ACK` in 1: read accepted; MEM_DATA is valid in the same cycle.
- `MEM_DATA` in 16: RGB565 word.
- `HSYNC` out 1: HSYNC_IN delayed to align with RGB.
- `VSYNC` out 1: VSYNC_IN delayed to align with RGB.
- `DEN` out 1: DEN_IN delayed to align with RGB.
- `RGB` out 16: pixel data. Bits [15:11] are R, [10:5] are G, [4:0] are B.
- `UNDERRUN` out 1: sticky underrun flag; cleared only by RESET.

## Operation
- **Frame start:** a VSYNC_IN falling edge clears the line counter, the column counter and both buffer-ready flags, then queues a fetch of line 0 into buffer 0.
- **Line counting:**
  - Column counter: cleared on DEN_IN rising, incremented on each cycle with DEN_IN high.
  - Line counter: incremented on DEN_IN falling.
  - Line y always displays from buffer y[0].
- **Line start:** on DEN_IN rising for line y:
  - If y+1 < V_DISPLAY, queue a fetch of line y+1 into buffer (y+1)[0] and clear that buffer's ready flag.
  - On the last line, nothing is queued.
- **Fetch FSM:** IDLE → REQ → (last word acked) → IDLE.
  - In REQ, MEM_REQ is high and MEM_ADDR is held stable until MEM_ACK is sampled high.
  - The data is written to buffer[fill][word], and the next address is presented the following cycle.
  - After word H_DISPLAY−1 is acked, the fill buffer's ready flag is set.
- **Address generation:** a running line base advances by H_DISPLAY per line, with column offset added. There is no multiplier.
- **Abort on frame start:** a VSYNC_IN falling edge during REQ never drops an unacked request. The FSM completes the outstanding handshake, discards the data, then restarts at line 0. A queued fetch is held until the FSM reaches IDLE.
- **Display read:** the line buffer is read at the column counter address. The read is synchronous.

## Timing
- Latency is fixed at 2 PIXEL_CLK cycles. HSYNC, VSYNC and DEN equal their inputs delayed 2 cycles, and RGB is aligned to DEN.
- RGB is forced to 0 whenever DEN is low.
- Reset values:
  - HSYNC = 1 and VSYNC = 1.
  - DEN = 0, RGB = 0, MEM_REQ = 0, MEM_ADDR = 0, UNDERRUN = 0.
  - FSM in IDLE; both ready flags clear.
- RESET mid-handshake drops MEM_REQ the next cycle. The memory must tolerate an abandoned request.
- Peak fetch rate is 1 word per cycle. The memory must sustain H_DISPLAY acks within one line period.
- Underrun is evaluated at DEN_IN rising: if the display buffer's ready flag is clear, the line is underrun.

## Configuration
- `LCD_LINE_FETCH_UNDERRUN_EN` defined:
  - For an underrun line, every pixel of that line outputs 16'hF81F (magenta).
  - UNDERRUN is set on the first pixel of the line.
- Not defined:
  - UNDERRUN is tied to 0.
  - The buffer is displayed regardless, so stale or partial data is visible.
  - The underrun logic is not synthesised.

## Test plan
All scenarios use H_DISPLAY=8 and V_DISPLAY=4, with memory word = address.
- **Zero-wait memory, full frame:** line 1 pixels show RGB 8..15, and DEN is aligned 2 cycles after DEN_IN.
- **Handshake:** MEM_ACK delayed 3 cycles per word → MEM_ADDR is stable while MEM_REQ is high, and no word is skipped or duplicated.
- **Fetch too slow (macro defined):** MEM_ACK every 4th cycle with a short blanking interval → line 1 is all 16'hF81F, UNDERRUN=1 and stays 1, and a later fully fetched line is shown correctly.
- **Mid-fetch VSYNC:** VSYNC_IN falls during the fetch of line 2 → the outstanding ack completes, the next MEM_ADDR is 0, and the new frame's line 0 shows 0..7.
- **Reset mid-request:** RESET asserted while MEM_REQ=1 → the next cycle has MEM_REQ=0, HSYNC=VSYNC=1, DEN=0, RGB=0, UNDERRUN=0.
- **Macro undefined, slow memory:** the same stimulus as the fetch-too-slow case → UNDERRUN stays 0 and there is no magenta output.
